// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode constants, instruction field
// positions, default datapath widths and the CeilLog2 helper.
package mips_pkg;

    // Width of a register-file word and the index width derived from it.
    localparam int WORD_LENGTH_DEFAULT = 32;

    // Smallest n such that 2**n >= value; evaluated at elaboration time only.
    function automatic int CeilLog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int NBITS_DEFAULT = CeilLog2(WORD_LENGTH_DEFAULT);

    // Opcodes this stage cares about.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;

    // Instruction field positions (MIPS32 encoding).
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;

    // Single-entry load scoreboard states.
    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_PEND = 1'b1
    } sb_state_t;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection for operand_fetch.
// Holds a single-entry scoreboard of the destination of the one outstanding
// load and raises hazard when the presented instruction must wait.
// Build option OPERAND_FETCH_BYPASS_EN: when undefined, an instruction whose
// source is being written back in the same cycle also stalls for one cycle,
// because the fetch stage then has no capture bypass.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [NBITS-1:0] rs,
    input  logic [NBITS-1:0] rt,
    input  logic             is_load,
    input  logic             load_accept,
    input  logic             wb_write,
    input  logic [NBITS-1:0] wb_reg,
    output logic             hazard
);

    sb_state_t        state;
    sb_state_t        state_next;
    logic [NBITS-1:0] pend_reg;
    logic [NBITS-1:0] pend_reg_next;
    logic             clear_now;
    logic             hazard_pend;
    logic             hazard_wb;

    // The outstanding load is being written back this very cycle.
    assign clear_now = (state == SB_PEND) && wb_write && (wb_reg == pend_reg);

    // Stall on a read of the pending destination, or on any further load
    // while the single scoreboard entry is occupied.
    assign hazard_pend = (state == SB_PEND) && in_valid && !clear_now &&
                         ((rs == pend_reg) || (rt == pend_reg) || is_load);

`ifdef OPERAND_FETCH_BYPASS_EN
    assign hazard_wb = 1'b0;
`else
    // Without a capture bypass the register file would return the old value,
    // so wait one cycle for the write to land.
    assign hazard_wb = in_valid && wb_write && (wb_reg != '0) &&
                       ((wb_reg == rs) || (wb_reg == rt));
`endif

    assign hazard = hazard_pend || hazard_wb;

    // Scoreboard state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state    <= SB_IDLE;
            pend_reg <= '0;
        end else begin
            state    <= state_next;
            pend_reg <= pend_reg_next;
        end
    end

    // Scoreboard next state: clear on write-back, re-arm on an accepted load.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned, which
        // would otherwise infer a latch.
        state_next    = state;
        pend_reg_next = pend_reg;
        if (clear_now) begin
            state_next = SB_IDLE;
        end
        if (load_accept && (rt != '0)) begin
            state_next    = SB_PEND;
            pend_reg_next = rt;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode / operand-fetch stage in front of the ALU.
// Drives the register-file read ports from the incoming instruction, captures
// operands and decoded fields into an output register with a valid/ready
// handshake, keeps held operands coherent with write-back, and stalls on
// load-use hazards reported by hazard_unit.
// Build option OPERAND_FETCH_BYPASS_EN: when defined, write-back data is
// forwarded into the operands on the accept edge instead of stalling.
module operand_fetch
    import mips_pkg::*;
#(
    parameter int WORD_LENGTH = WORD_LENGTH_DEFAULT,
    parameter int NBITS       = CeilLog2(WORD_LENGTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    output logic [NBITS-1:0]       Read_Reg1,
    output logic [NBITS-1:0]       Read_Reg2,
    input  logic [WORD_LENGTH-1:0] Read_Data1,
    input  logic [WORD_LENGTH-1:0] Read_Data2,
    input  logic                   wb_write,
    input  logic [NBITS-1:0]       wb_reg,
    input  logic [WORD_LENGTH-1:0] wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] out_a,
    output logic [WORD_LENGTH-1:0] out_b,
    output logic [NBITS-1:0]       out_rd,
    output logic [WORD_LENGTH-1:0] out_imm,
    output logic                   out_is_load
);

    logic [5:0]             opcode;
    logic [NBITS-1:0]       rs;
    logic [NBITS-1:0]       rt;
    logic [NBITS-1:0]       rd;
    logic [NBITS-1:0]       dest;
    logic [WORD_LENGTH-1:0] imm_ext;
    logic                   is_load;
    logic                   hazard;
    logic                   accept;
    logic                   load_accept;
    logic [WORD_LENGTH-1:0] cap_a;
    logic [WORD_LENGTH-1:0] cap_b;
    logic [NBITS-1:0]       held_rs;
    logic [NBITS-1:0]       held_rt;
    logic                   snoop_a;
    logic                   snoop_b;

    // Field decode.
    assign opcode  = in_instr[OPCODE_HI:OPCODE_LO];
    assign rs      = NBITS'(in_instr[RS_HI:RS_LO]);
    assign rt      = NBITS'(in_instr[RT_HI:RT_LO]);
    assign rd      = NBITS'(in_instr[RD_HI:RD_LO]);
    assign is_load = (opcode == OP_LW);
    assign dest    = (opcode == OP_RTYPE) ? rd : rt;
    assign imm_ext = {{(WORD_LENGTH-16){in_instr[IMM_HI]}}, in_instr[IMM_HI:IMM_LO]};

    assign Read_Reg1 = rs;
    assign Read_Reg2 = rt;

    // Handshake.
    assign in_ready    = (!out_valid || out_ready) && !hazard;
    assign accept      = in_valid && in_ready;
    assign load_accept = accept && is_load;

    hazard_unit #(
        .NBITS (NBITS)
    ) u_hazard (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .rs          (rs),
        .rt          (rt),
        .is_load     (is_load),
        .load_accept (load_accept),
        .wb_write    (wb_write),
        .wb_reg      (wb_reg),
        .hazard      (hazard)
    );

    // Operand selection at capture: r0 reads as zero, optionally forward write-back.
    always_comb begin
        cap_a = Read_Data1;
        cap_b = Read_Data2;
`ifdef OPERAND_FETCH_BYPASS_EN
        if (wb_write && (wb_reg == rs)) begin
            cap_a = wb_data;
        end
        if (wb_write && (wb_reg == rt)) begin
            cap_b = wb_data;
        end
`endif
        if (rs == '0) begin
            cap_a = '0;
        end
        if (rt == '0) begin
            cap_b = '0;
        end
    end

    // A write-back to a held source register refreshes the stalled operand.
    assign snoop_a = wb_write && (wb_reg != '0) && (wb_reg == held_rs);
    assign snoop_b = wb_write && (wb_reg != '0) && (wb_reg == held_rt);

    // Output register: load on accept, drain on consume, snoop while held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
            out_rd      <= '0;
            out_imm     <= '0;
            out_is_load <= 1'b0;
            held_rs     <= '0;
            held_rt     <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_a       <= cap_a;
            out_b       <= cap_b;
            out_rd      <= dest;
            out_imm     <= imm_ext;
            out_is_load <= is_load;
            held_rs     <= rs;
            held_rt     <= rt;
        end else if (out_valid) begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end else begin
                if (snoop_a) begin
                    out_a <= wb_data;
                end
                if (snoop_b) begin
                    out_b <= wb_data;
                end
            end
        end
    end

endmodule
